// File: rtl/pc_addr_unit_pkg.sv
// Shared constants and encodings for the PC/address unit, controller and datapath.
// Pure definitions: no logic, no latency, no backpressure.
package pc_addr_unit_pkg;

  localparam int AW_DEF       = 9;
  localparam int DW_DEF       = 16;
  localparam int CNT_W_DEF    = 16;
  localparam int RESET_PC_DEF = 0;

  // Register-file write-back source; LR selects this unit's lr_out.
  typedef enum logic [1:0] {
    VSEL_C     = 2'b00,
    VSEL_LR    = 2'b01,
    VSEL_IMM   = 2'b10,
    VSEL_MDATA = 2'b11
  } vsel_e;

  typedef enum logic [2:0] {
    NSEL_RN = 3'b001,
    NSEL_RD = 3'b010,
    NSEL_RM = 3'b100
  } nsel_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_e;

endpackage

// File: rtl/pc_addr_unit_next.sv
// Next-PC select (tsel > execb > rsel), PC+1 and PC+1+offset, all modulo 2^AW.
// Purely combinational; no backpressure.
module pc_next_mux
  import pc_addr_unit_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic [AW-1:0] i_pc,
  input  logic [DW-1:0] i_sximm8,
  input  logic [DW-1:0] i_target_in,
  input  logic          i_rsel,
  input  logic          i_reset_pc,
  input  logic          i_execb,
  input  logic          i_tsel,
  output logic [AW-1:0] o_next_pc,
  output logic          o_pc_load,
  output logic [AW-1:0] o_pc_plus1
);

  logic w_unused_hi;
  assign w_unused_hi = ^{i_sximm8[DW-1:AW], i_target_in[DW-1:AW]};

  assign o_pc_plus1 = i_pc + AW'(1);
  assign o_pc_load  = i_tsel | i_execb | i_rsel;

  always_comb begin
    o_next_pc = i_pc;
    if (i_tsel)
      o_next_pc = i_target_in[AW-1:0];
    else if (i_execb)
      o_next_pc = o_pc_plus1 + i_sximm8[AW-1:0];
    else if (i_rsel)
      o_next_pc = i_reset_pc ? AW'(RESET_PC) : o_pc_plus1;
  end

endmodule

// File: rtl/pc_addr_unit.sv
// PC, data-address register, fetch counter and halt flag; registered state updates in one cycle.
// mem_addr and lr_out are combinational from registers; no backpressure.
module pc_addr_unit
  import pc_addr_unit_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_reset_pc,
  input  logic             i_rsel,
  input  logic             i_execb,
  input  logic             i_tsel,
  input  logic             i_addr_sel,
  input  logic             i_load_addr,
  input  logic             i_load_ir,
  input  logic             i_w8,
  input  logic [DW-1:0]    i_sximm8,
  input  logic [DW-1:0]    i_target_in,
  input  logic [DW-1:0]    i_alu_in,
  output logic [AW-1:0]    o_pc,
  output logic [AW-1:0]    o_mem_addr,
  output logic [DW-1:0]    o_lr_out,
  output logic [CNT_W-1:0] o_instr_cnt,
  output logic             o_halted
);

  logic [AW-1:0]    r_pc;
  logic [AW-1:0]    r_da;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             r_halted;
  logic [AW-1:0]    w_next_pc;
  logic [AW-1:0]    w_pc_plus1;
  logic             w_pc_load;
  logic             w_unused_alu;

  assign w_unused_alu = ^i_alu_in[DW-1:AW];

  pc_next_mux #(
    .AW       (AW),
    .DW       (DW),
    .RESET_PC (RESET_PC)
  ) u_next (
    .i_pc        (r_pc),
    .i_sximm8    (i_sximm8),
    .i_target_in (i_target_in),
    .i_rsel      (i_rsel),
    .i_reset_pc  (i_reset_pc),
    .i_execb     (i_execb),
    .i_tsel      (i_tsel),
    .o_next_pc   (w_next_pc),
    .o_pc_load   (w_pc_load),
    .o_pc_plus1  (w_pc_plus1)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc        <= AW'(RESET_PC);
      r_da        <= '0;
      r_instr_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      if (w_pc_load)
        r_pc <= w_next_pc;
      if (i_load_addr)
        r_da <= i_alu_in[AW-1:0];
      // Saturate so a long-running program never shows a misleading small count.
      if (i_load_ir && (r_instr_cnt != '1))
        r_instr_cnt <= r_instr_cnt + 1'b1;
      if (i_w8)
        r_halted <= 1'b1;
    end
  end

  assign o_pc        = r_pc;
  assign o_mem_addr  = i_addr_sel ? r_pc : r_da;
  // Built from the registered PC so BL captures the link before execb moves the PC.
  assign o_lr_out    = DW'(w_pc_plus1);
  assign o_instr_cnt = r_instr_cnt;
  assign o_halted    = r_halted;

endmodule

// File: tb/tb_pc_addr_unit.sv
// Scoreboard bench for pc_addr_unit: expected state pushed per driven cycle, popped after the edge.
module tb_pc_addr_unit;
  localparam int AW    = 9;
  localparam int DW    = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0, reset_pc = 1'b0, rsel = 1'b0, execb = 1'b0, tsel = 1'b0;
  logic addr_sel = 1'b1, load_addr = 1'b0, load_ir = 1'b0, w8 = 1'b0;
  logic [DW-1:0] sximm8 = '0, target_in = '0, alu_in = '0;
  logic [AW-1:0] pc, mem_addr;
  logic [DW-1:0] lr_out;
  logic [CNT_W-1:0] instr_cnt;
  logic halted;

  typedef struct packed {
    logic [AW-1:0]    pc;
    logic [AW-1:0]    da;
    logic [CNT_W-1:0] cnt;
    logic             halted;
  } exp_t;

  exp_t sb[$];
  exp_t m = '0;
  int total = 0;
  int bad = 0;

  pc_addr_unit #(.AW(AW), .DW(DW), .CNT_W(CNT_W), .RESET_PC(0)) dut (
    .i_clk(clk), .i_reset(reset), .i_reset_pc(reset_pc), .i_rsel(rsel),
    .i_execb(execb), .i_tsel(tsel), .i_addr_sel(addr_sel), .i_load_addr(load_addr),
    .i_load_ir(load_ir), .i_w8(w8), .i_sximm8(sximm8), .i_target_in(target_in),
    .i_alu_in(alu_in), .o_pc(pc), .o_mem_addr(mem_addr), .o_lr_out(lr_out),
    .o_instr_cnt(instr_cnt), .o_halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rst, input logic rs, input logic rp,
                     input logic ex, input logic ts, input logic la, input logic li,
                     input logic wt, input logic [DW-1:0] sx, input logic [DW-1:0] tg,
                     input logic [DW-1:0] al);
    exp_t n;
    reset = rst; rsel = rs; reset_pc = rp; execb = ex; tsel = ts;
    load_addr = la; load_ir = li; w8 = wt; sximm8 = sx; target_in = tg; alu_in = al;
    n = m;
    if (rst) begin
      n = '0;
    end else begin
      if (ts)      n.pc = tg[AW-1:0];
      else if (ex) n.pc = m.pc + AW'(1) + sx[AW-1:0];
      else if (rs) n.pc = rp ? AW'(0) : m.pc + AW'(1);
      if (la) n.da = al[AW-1:0];
      if (li && (m.cnt != {CNT_W{1'b1}})) n.cnt = m.cnt + 1'b1;
      if (wt) n.halted = 1'b1;
    end
    sb.push_back(n);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      n = sb.pop_front();
      chk({tag, ".pc"}, 32'(pc), 32'(n.pc));
      chk({tag, ".cnt"}, 32'(instr_cnt), 32'(n.cnt));
      chk({tag, ".halted"}, 32'(halted), 32'(n.halted));
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr_sel ? n.pc : n.da));
      m = n;
    end
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic jump(input string tag, input logic [DW-1:0] tg);
    cyc(tag, 0, 0, 0, 0, 1, 0, 0, 0, '0, tg, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, then a reset_pc fetch.
    cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    chk("reset.lr", 32'(lr_out), 32'd1);
    cyc("rstpc", 0, 1, 1, 0, 0, 0, 0, 0, '0, '0, '0);
    chk("rstpc.pc0", 32'(pc), 32'd0);

    // Sequential increment and wrap.
    jump("to5", 16'd5);
    repeat (3) cyc("seq", 0, 1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    chk("seq.pc8", 32'(pc), 32'd8);
    jump("to511", 16'd511);
    cyc("wrap", 0, 1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    chk("wrap.pc0", 32'(pc), 32'd0);

    // Branches.
    jump("to10a", 16'd10);
    cyc("br_neg", 0, 0, 0, 1, 0, 0, 0, 0, 16'hFFFD, '0, '0);
    chk("br_neg.pc8", 32'(pc), 32'd8);
    jump("to10b", 16'd10);
    cyc("br_pos", 0, 0, 0, 1, 0, 0, 0, 0, 16'd4, '0, '0);
    chk("br_pos.pc15", 32'(pc), 32'd15);
    cyc("br_rsel", 0, 1, 1, 1, 0, 0, 0, 0, 16'd4, '0, '0);
    chk("br_rsel.pc20", 32'(pc), 32'd20);

    // Link value and register jumps.
    chk("lr21", 32'(lr_out), 32'd21);
    jump("bx", 16'h0123);
    chk("bx.pc", 32'(pc), 32'h123);
    cyc("tsel_execb", 0, 1, 0, 1, 1, 0, 0, 0, 16'd4, 16'hFEAB, '0);
    chk("tsel_execb.pc", 32'(pc), 32'h0AB);

    // Backward branch wrapping below zero, link wrap, reset_pc alone, hold.
    jump("to0", 16'd0);
    cyc("br_under", 0, 0, 0, 1, 0, 0, 0, 0, 16'hFFFE, '0, '0);
    chk("br_under.pc511", 32'(pc), 32'd511);
    chk("lr_wrap", 32'(lr_out), 32'd0);
    cyc("rp_only", 0, 0, 1, 0, 0, 0, 0, 0, '0, '0, '0);
    idle("hold");

    // Data address register, loaded alongside a PC strobe.
    addr_sel = 1'b0;
    cyc("da_load", 0, 1, 0, 0, 0, 1, 0, 0, '0, '0, 16'hFE07);
    chk("da.mem7", 32'(mem_addr), 32'd7);
    idle("da_hold");
    addr_sel = 1'b1;
    #1;
    chk("da.mem_pc", 32'(mem_addr), 32'(m.pc));

    // Counter saturation and sticky halt.
    repeat (260) cyc("fetch", 0, 0, 0, 0, 0, 0, 1, 0, '0, '0, '0);
    chk("cnt_sat", 32'(instr_cnt), 32'd255);
    cyc("halt", 0, 0, 0, 0, 0, 0, 0, 1, '0, '0, '0);
    repeat (2) idle("halt_hold");
    chk("halt_sticky", 32'(halted), 32'd1);

    // Reset overrides every strobe.
    addr_sel = 1'b0;
    cyc("reset_all", 1, 1, 1, 1, 1, 1, 1, 1, 16'd4, 16'h0055, 16'h00AA);
    chk("reset_all.mem", 32'(mem_addr), 32'd0);
    chk("reset_all.cnt", 32'(instr_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
